// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
`timescale 1ns/100ps
package clk_div_pkg;
    localparam int unsigned RATIO_IDLE = 0;

    // Number of clkin periods pos_q stays high: N/2 for even N, (N-1)/2 for odd N.
    function automatic logic [31:0] hi_cycles(input logic [31:0] n);
        return n >> 1;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, posedge/negedge phase registers, end-of-period tick,
// and a negedge-gated clkin bypass for ratio 1.
`timescale 1ns/100ps
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] ratio,
    output logic             clkout,
    output logic             tick
);
    localparam logic [WIDTH-1:0] IDLE = WIDTH'(RATIO_IDLE);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] act, cnt, next_act, next_cnt, hi;
    logic             load, pos_q, neg_q, run_n, tick_q;

    // Idle is tested first, so act - 1 never matters while act is zero.
    always_comb begin
        load     = (act == IDLE) || (cnt == act - ONE) || sync;
        next_act = act;
        next_cnt = cnt + ONE;
        if (load) begin
            next_act = en ? ratio : IDLE;
            next_cnt = '0;
        end
        hi = WIDTH'(hi_cycles(32'(next_act)));
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            act    <= IDLE;
            cnt    <= '0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act    <= next_act;
            cnt    <= next_cnt;
            pos_q  <= (next_act != IDLE) && (next_cnt < hi);
            tick_q <= (next_act != IDLE) && (next_cnt == next_act - ONE);
        end
    end

    // Negedge state: half-cycle stretch for odd ratios, and the clkin gate for ratio 1
    // (changing it while clkin is low keeps the gated clock glitch-free).
    always_ff @(negedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            run_n <= 1'b0;
        end else begin
            neg_q <= pos_q;
            run_n <= (act == ONE);
        end
    end

    assign clkout = (clkin & run_n) | pos_q | (act[0] & neg_q);
    assign tick   = tick_q;
endmodule

// File: rtl/clk_div_n.sv
// Multi-channel programmable 50%-duty clock divider; slices per-channel ratio/enable
// and fans the common sync strobe out to every channel.
`timescale 1ns/100ps
module clk_div_n
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic                 sync,
    input  logic [NCH*WIDTH-1:0] ratio,
    output logic [NCH-1:0]       clkout,
    output logic [NCH-1:0]       tick
);
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        clk_div_chan #(.WIDTH(WIDTH)) u_chan (
            .clkin  (clkin),
            .rst_n  (rst_n),
            .en     (en[c]),
            .sync   (sync),
            .ratio  (ratio[c*WIDTH +: WIDTH]),
            .clkout (clkout[c]),
            .tick   (tick[c])
        );
    end
endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
- Multi-channel programmable clock divider, clkin domain; generalises the fixed divide-by-5 to any ratio 1..2^WIDTH-1 per channel.
- Each channel produces a 50%-duty clock for odd and even ratios, using posedge and negedge state.
- Ratio and enable changes apply only at period boundaries, so the output never glitches.
- A common sync input phase-aligns all channels; a per-channel end-of-period tick is provided for pixel-config sequencing logic.

Parameters:
WIDTH, 8, ratio bits per channel
NCH, 4, number of output channels

Ports:
clkin  in  1  input clock; every register in the block uses it
rst_n  in  1  asynchronous active-low reset
en  in  NCH  per-channel enable
sync  in  1  phase-align strobe, clkin-synchronous, 1 cycle
ratio  in  NCH*WIDTH  divide ratio, channel c at [c*WIDTH +: WIDTH]
clkout  out  NCH  divided clocks
tick  out  NCH  1-cycle pulse (posedge-registered) in the last clkin cycle of each output period

Behaviour:
- Reset (rst_n low, async): cnt=0, act_ratio=0 (idle), pos_q=0, neg_q=0, tick=0, clkout=0. All outputs stay low until load.
- Per channel, state on posedge:
  - act_ratio[WIDTH], cnt[WIDTH], pos_q.
  - neg_q is pos_q resampled on negedge.
- Idle: when act_ratio==0 or channel stopped, clkout=0.
- Load/boundary condition, evaluated each posedge:
  - Condition is (idle) OR (cnt==act_ratio-1) OR sync.
  - When true: act_ratio<=(en[c] ? ratio_c : 0) and cnt<=0.
  - Otherwise: cnt<=cnt+1.
- pos_q is registered from next-state: pos_q <= (next_act!=0) && (next_cnt < hi), where hi uses next_act:
  - even N: hi=N/2; clkout=pos_q.
  - odd N>=3: hi=(N-1)/2; clkout=pos_q|neg_q (high N/2 clkin periods).
  - N=1: clkout=clkin & run_n, where run_n is registered on negedge (no glitch); tick constantly high while active.
- Timing: clkout rises on the same posedge the load occurs (cnt becomes 0). Latency from ratio valid to first clkout rise: 1 posedge when idle, otherwise the end of the current period.
- tick_c registered: tick<= (next_act!=0) && (next_cnt==next_act-1). For N=1 this holds continuously.
- Ratio change mid-period: ignored until the boundary; the current period completes with the old ratio.
- en falls mid-period: the current period completes, then the channel goes idle with clkout low.
- en rises while idle: the channel loads on the next posedge.
- sync:
  - Overrides boundary timing: all enabled channels load ratio and restart cnt=0 on the same posedge, so all clkout rise on that edge.
  - This truncates the current period; the resulting short high/low is accepted and documented.
  - neg_q is cleared on the negedge following sync when the new hi==0.
- Simultaneous sync + en low: the channel goes idle.
- Reset mid-operation: clkout drops immediately (async).
- ratio=0 with en=1: treated as disabled.
- Counter width WIDTH; compare act_ratio-1 computed in WIDTH bits; act_ratio=0 never reaches the compare because idle is checked first.

Decomposition:
- Package clk_div_pkg:
  - RATIO_IDLE = 0
  - function hi_cycles(N) returning N/2 for even N, (N-1)/2 for odd N
- Sub-module clk_div_chan: one channel (counter, pos/neg registers, tick, N=1 bypass). Instantiated NCH times by generate in clk_div_n.
- Top-level clk_div_n: ratio/en slicing and sync fan-out.

Test Plan:
- Clock period 2 ns, rst_n low then released at 199 ns, ch0 ratio=5 en=1 -> clkout0 first rises at first posedge after release; period 10 ns, high 5 ns; tick0 pulses every 10 ns in the last 2 ns.
- ratio 4 / 3 / 1 / 0 on ch1..ch3 and ch0 -> ch1 period 8 ns, high 4 ns; ch2 period 6 ns, high 3 ns; ch3 equals clkin; ch0 held low.
- Change ch0 ratio 5->6 at mid-period -> current 10 ns period completes, next period is 12 ns, high 6 ns, no glitch (no pulse <2 ns).
- Ch0 ratio=5 and ch1 ratio=3 free-running, sync pulse -> both clkout rise on the posedge following sync; thereafter rising edges coincide every 30 ns.
- Deassert en0 mid-period -> period completes, clkout0 stays low; re-assert -> restarts on next posedge with full 5 ns high.
- Assert rst_n low mid-high-phase -> clkout and tick go low immediately without waiting for a clkin edge; after release, behaviour matches first scenario.
